// File: rtl/iic_slave_rx.sv
// I2C target-side write receiver.
// Watches SCL/SDA, detects START/STOP, matches a 7-bit write address,
// shifts in data bytes and ACKs/NACKs them on open-drain SDA.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   en          : block enable (low forces IDLE, SDA released)
//   rx_ready    : consumer can accept a byte (sampled on 8th data bit)
//   scl         : I2C clock from master (input only)
//   sda         : I2C data, driven only 0 or z
//   rx_data     : last accepted byte
//   rx_valid    : one-clk strobe, rx_data newly valid
//   start_det   : one-clk strobe on START / repeated START
//   stop_det    : one-clk strobe on STOP
//   addr_hit    : high from address ACK until STOP / next START
//   overrun     : one-clk strobe when a byte is dropped (rx_ready low)
//   busy        : high from START to STOP
module iic_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx_ready,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       addr_hit,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_DATA_ACK  = 3'd4;
    localparam logic [2:0] S_WAIT_STOP = 3'd5;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_p, stop_p;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       shift, shift_n;
    logic             sda_oe, sda_oe_n;
    logic             acked, acked_n;
    logic [7:0]       rx_data_n;
    logic             rx_valid_n, start_det_n, stop_det_n;
    logic             addr_hit_n, overrun_n, busy_n;
    logic [7:0]       byte_in;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronizers reset to the idle-bus level so no edge is seen on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_d    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start_p  <= 1'b0;
            stop_p   <= 1'b0;
        end else begin
            scl_s1   <= scl;
            scl_s2   <= scl_s1;
            scl_d    <= scl_s2;
            sda_s1   <= sda;
            sda_s2   <= sda_s1;
            sda_d    <= sda_s2;
            scl_rise <= scl_s2 & ~scl_d;
            scl_fall <= ~scl_s2 & scl_d;
            start_p  <= scl_s2 & scl_d & sda_d & ~sda_s2;
            stop_p   <= scl_s2 & scl_d & ~sda_d & sda_s2;
        end
    end

    assign byte_in = {shift[6:0], sda_s2};

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_n     = shift;
        sda_oe_n    = sda_oe;
        acked_n     = acked;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        start_det_n = 1'b0;
        stop_det_n  = 1'b0;
        overrun_n   = 1'b0;
        addr_hit_n  = addr_hit;
        busy_n      = busy;

        if (!en) begin
            state_n    = S_IDLE;
            cnt_n      = '0;
            sda_oe_n   = 1'b0;
            addr_hit_n = 1'b0;
            busy_n     = 1'b0;
        end else if (start_p) begin
            start_det_n = 1'b1;
            state_n     = S_ADDR;
            cnt_n       = '0;
            sda_oe_n    = 1'b0;
            addr_hit_n  = 1'b0;
            busy_n      = 1'b1;
        end else if (stop_p) begin
            stop_det_n = 1'b1;
            state_n    = S_IDLE;
            cnt_n      = '0;
            sda_oe_n   = 1'b0;
            addr_hit_n = 1'b0;
            busy_n     = 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise && cnt < CNT_W'(8)) begin
                        shift_n = byte_in;
                        cnt_n   = cnt + CNT_W'(1);
                    end else if (scl_fall && cnt == CNT_W'(8)) begin
                        if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                            sda_oe_n   = 1'b1;
                            addr_hit_n = 1'b1;
                            state_n    = S_ADDR_ACK;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = '0;
                        state_n  = S_DATA;
                    end
                end
                S_DATA: begin
                    if (scl_rise && cnt < CNT_W'(8)) begin
                        shift_n = byte_in;
                        cnt_n   = cnt + CNT_W'(1);
                        // Byte completes on the 8th rise; accept or drop now.
                        if (cnt == CNT_W'(7)) begin
                            if (rx_ready) begin
                                rx_data_n  = byte_in;
                                rx_valid_n = 1'b1;
                                acked_n    = 1'b1;
                            end else begin
                                overrun_n = 1'b1;
                                acked_n   = 1'b0;
                            end
                        end
                    end else if (scl_fall && cnt == CNT_W'(8)) begin
                        sda_oe_n = acked;
                        state_n  = S_DATA_ACK;
                    end
                end
                S_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = '0;
                        state_n  = acked ? S_DATA : S_WAIT_STOP;
                    end
                end
                default: begin
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shift     <= '0;
            sda_oe    <= 1'b0;
            acked     <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            addr_hit  <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift     <= shift_n;
            sda_oe    <= sda_oe_n;
            acked     <= acked_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            start_det <= start_det_n;
            stop_det  <= stop_det_n;
            addr_hit  <= addr_hit_n;
            overrun   <= overrun_n;
            busy      <= busy_n;
        end
    end

endmodule
